brent_kung_pipe: RTL

Parametrised, pipelined Brent-Kung adder/subtractor with valid/ready flow control. It generalises the fixed 4-bit combinational adder to a power-of-two width WIDTH, adds a subtract mode, overflow and zero flags, and an optional mid-tree pipeline register. It sits between an operand source and a result consumer, sustaining one operation per cycle with full backpressure.

---
 rtl/brent_kung_pipe_pkg.sv | 40 ++++
 rtl/brent_kung_pipe_black_cell.sv | 19 +
 rtl/brent_kung_pipe.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/brent_kung_pipe_pkg.sv
// Shared definitions for the pipelined Brent-Kung adder/subtractor:
// operation encoding, prefix-cell operators and the width legality check.
package bk_pkg;

  localparam logic BK_OP_ADD = 1'b0;
  localparam logic BK_OP_SUB = 1'b1;

  // Generate/propagate pair; g is the MSB so {g, p} concatenations line up.
  typedef struct packed {
    logic g;
    logic p;
  } bk_gp_t;

  // Grey cell: bit-level generate and propagate from the two operand bits.
  function automatic bk_gp_t bk_grey(input logic a, input logic b);
    bk_gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

  // Black cell: merge a higher group (hi) with the adjacent lower group (lo).
  function automatic bk_gp_t bk_black(input bk_gp_t hi, input bk_gp_t lo);
    bk_gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Green cell: fold the carry-in into a group prefix to get the carry out of it.
  function automatic logic bk_green(input bk_gp_t gp, input logic c0);
    return gp.g | (gp.p & c0);
  endfunction

  // Legal widths are powers of two from 4 to 64.
  function automatic bit bk_width_ok(input int w);
    return (w >= 4) && (w <= 64) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/brent_kung_pipe_black_cell.sv
// One Brent-Kung black operator, instanced throughout the prefix tree.
module bk_black_cell
  import bk_pkg::*;
(
  input  logic i_g_hi,
  input  logic i_p_hi,
  input  logic i_g_lo,
  input  logic i_p_lo,
  output logic o_g,
  output logic o_p
);

  bk_gp_t w_res;

  assign w_res = bk_black({i_g_hi, i_p_hi}, {i_g_lo, i_p_lo});
  assign o_g   = w_res.g;
  assign o_p   = w_res.p;

endmodule

// File: rtl/brent_kung_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Stages: operand register S0 -> up-sweep -> optional S1 -> down-sweep ->
// output register. One shared advance signal moves every stage at once.
module brent_kung_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MID_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int LG = $clog2(WIDTH);

  if (!bk_width_ok(WIDTH)) begin : g_bad_width
    $error("brent_kung_pipe: WIDTH must be a power of two in 4..64");
  end

  genvar gl, gi;

  // Pipeline moves whenever the output slot is empty or being drained;
  // no skid buffer, so in_ready follows out_ready combinationally.
  logic w_advance;
  logic r_out_valid;
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;

  // Subtract is A + ~B + 1, so the carry-in is forced high and in_cin ignored.
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  assign w_b_eff = (in_op == BK_OP_SUB) ? ~in_b : in_b;
  assign w_c0    = (in_op == BK_OP_ADD) ? in_cin : 1'b1;

  logic             r_s0_valid;
  logic [WIDTH-1:0] r_s0_a;
  logic [WIDTH-1:0] r_s0_b;
  logic             r_s0_c0;

  // S0: capture conditioned operands on accept; a non-accept shifts in a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
      r_s0_c0    <= 1'b0;
    end else if (w_advance) begin
      r_s0_valid <= in_valid;
      if (in_valid) begin
        r_s0_a  <= in_a;
        r_s0_b  <= w_b_eff;
        r_s0_c0 <= w_c0;
      end
    end
  end

  // Grey cells: per-bit generate/propagate.
  logic [WIDTH-1:0] w_bit_g, w_bit_p;
  for (gi = 0; gi < WIDTH; gi++) begin : g_grey
    assign {w_bit_g[gi], w_bit_p[gi]} = bk_grey(r_s0_a[gi], r_s0_b[gi]);
  end

  // Up-sweep: at level gl every bit i with (i+1) a multiple of 2^gl absorbs
  // the group ending 2^(gl-1) below it. Afterwards bits 2^k-1 hold [i:0].
  for (gl = 0; gl <= LG; gl++) begin : g_up
    logic [WIDTH-1:0] w_g, w_p;
    if (gl == 0) begin : g_leaf
      assign w_g = w_bit_g;
      assign w_p = w_bit_p;
    end else begin : g_lvl
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (((gi + 1) % (1 << gl)) == 0) begin : g_black
          bk_black_cell u_cell (
            .i_g_hi (g_up[gl-1].w_g[gi]),
            .i_p_hi (g_up[gl-1].w_p[gi]),
            .i_g_lo (g_up[gl-1].w_g[gi - (1 << (gl - 1))]),
            .i_p_lo (g_up[gl-1].w_p[gi - (1 << (gl - 1))]),
            .o_g    (w_g[gi]),
            .o_p    (w_p[gi])
          );
        end else begin : g_pass
          assign w_g[gi] = g_up[gl-1].w_g[gi];
          assign w_p[gi] = g_up[gl-1].w_p[gi];
        end
      end
    end
  end

  // Signals feeding the down-sweep, either registered (S1) or straight through.
  logic             w_mid_valid;
  logic [WIDTH-1:0] w_mid_g, w_mid_p, w_mid_bitp;
  logic             w_mid_c0;

  if (MID_REG != 0) begin : g_mid
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_g, r_s1_p, r_s1_bitp;
    logic             r_s1_c0;

    // S1: hold the up-sweep result, bit propagates and carry-in between tree halves.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1_valid <= 1'b0;
        r_s1_g     <= '0;
        r_s1_p     <= '0;
        r_s1_bitp  <= '0;
        r_s1_c0    <= 1'b0;
      end else if (w_advance) begin
        r_s1_valid <= r_s0_valid;
        if (r_s0_valid) begin
          r_s1_g    <= g_up[LG].w_g;
          r_s1_p    <= g_up[LG].w_p;
          r_s1_bitp <= w_bit_p;
          r_s1_c0   <= r_s0_c0;
        end
      end
    end

    assign w_mid_valid = r_s1_valid;
    assign w_mid_g     = r_s1_g;
    assign w_mid_p     = r_s1_p;
    assign w_mid_bitp  = r_s1_bitp;
    assign w_mid_c0    = r_s1_c0;
  end else begin : g_no_mid
    assign w_mid_valid = r_s0_valid;
    assign w_mid_g     = g_up[LG].w_g;
    assign w_mid_p     = g_up[LG].w_p;
    assign w_mid_bitp  = w_bit_p;
    assign w_mid_c0    = r_s0_c0;
  end

  // Down-sweep: span D runs from LG-1 down to 1; bit i with (i+1) mod 2^D equal
  // to 2^(D-1) (and above the first block) picks up the finished prefix below it.
  for (gl = 0; gl < LG; gl++) begin : g_dn
    logic [WIDTH-1:0] w_g, w_p;
    if (gl == 0) begin : g_src
      assign w_g = w_mid_g;
      assign w_p = w_mid_p;
    end else begin : g_lvl
      localparam int D = LG - gl;
      localparam int S = 1 << (D - 1);
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        if ((((gi + 1) % (1 << D)) == S) && (gi >= (1 << D))) begin : g_black
          bk_black_cell u_cell (
            .i_g_hi (g_dn[gl-1].w_g[gi]),
            .i_p_hi (g_dn[gl-1].w_p[gi]),
            .i_g_lo (g_dn[gl-1].w_g[gi - S]),
            .i_p_lo (g_dn[gl-1].w_p[gi - S]),
            .o_g    (w_g[gi]),
            .o_p    (w_p[gi])
          );
        end else begin : g_pass
          assign w_g[gi] = g_dn[gl-1].w_g[gi];
          assign w_p[gi] = g_dn[gl-1].w_p[gi];
        end
      end
    end
  end

  // Green cells: carry into bit i+1 from the full prefix [i:0] and c0.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  assign w_carry[0] = w_mid_c0;
  for (gi = 0; gi < WIDTH; gi++) begin : g_green
    assign w_carry[gi+1] = bk_green({g_dn[LG-1].w_g[gi], g_dn[LG-1].w_p[gi]}, w_mid_c0);
  end
  assign w_sum = w_mid_bitp ^ w_carry[WIDTH-1:0];

  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout, r_out_ovf, r_out_zero;

  // Output register: load a new result on advance, hold it while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= w_mid_valid;
      if (w_mid_valid) begin
        r_out_sum  <= w_sum;
        r_out_cout <= w_carry[WIDTH];
        r_out_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        r_out_zero <= ~|w_sum;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign out_zero  = r_out_zero;

endmodule
